lsu_ctrl: RTL and testbench

//  Load/store controller between datapath MEM stage and the 1024x32 word RAM (negedge write/read, one port).

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_lane_align.sv | 59 +++++
 rtl/lsu_ctrl.sv | 136 +++++++++++++
 tb/tb_lsu_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: access sizes, FSM states, RAM geometry.
// The misalignment helper is used only when MISALIGN_TRAP_EN is defined.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int RAM_AW = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Size 2'b11 is handled as a word access everywhere.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return lane[0];
         default: return lane != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a RAM word,
// and merges store data into a previously read word for sub-word stores.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        is_unsigned,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v     = 8'h00;
      half_v     = 16'h0000;
      load_data  = rword;
      store_word = wdata;

      case (lane)
         2'd0:    byte_v = rword[7:0];
         2'd1:    byte_v = rword[15:8];
         2'd2:    byte_v = rword[23:16];
         default: byte_v = rword[31:24];
      endcase
      // Halfword lane ignores lane[0]; misaligned halves are trapped upstream if enabled.
      half_v = lane[1] ? rword[31:16] : rword[15:0];

      case (size)
         SZ_BYTE: begin
            load_data  = {{24{~is_unsigned & byte_v[7]}}, byte_v};
            store_word = rword;
            case (lane)
               2'd0:    store_word[7:0]   = wdata[7:0];
               2'd1:    store_word[15:8]  = wdata[7:0];
               2'd2:    store_word[23:16] = wdata[7:0];
               default: store_word[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            load_data  = {{16{~is_unsigned & half_v[15]}}, half_v};
            store_word = rword;
            if (lane[1])
               store_word[31:16] = wdata[15:0];
            else
               store_word[15:0]  = wdata[15:0];
         end
         default: begin
            load_data  = rword;
            store_word = wdata;
         end
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller for a single-port, falling-edge 1024x32 RAM; sub-word stores use read-modify-write.
// Optional build macro MISALIGN_TRAP_EN: reject misaligned half/word accesses with rsp_err instead of touching RAM.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              ram_we,
   output logic [ADDR_W-3:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   state_t state_reg, state_next;

   logic              we_reg;
   logic [1:0]        size_reg;
   logic              uns_reg;
   logic [1:0]        lane_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [ADDR_W-3:0] ram_addr_reg;
   logic [DATA_W-1:0] ram_din_reg;
   logic [DATA_W-1:0] rsp_rdata_reg;
   logic              rsp_err_reg;

   logic              accept;
   logic              trap;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] store_word;

`ifdef MISALIGN_TRAP_EN
   assign trap = is_misaligned(req_size, req_addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   assign accept = req_valid & req_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   // ram_we decodes straight from state so an async reset removes it immediately.
   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      ram_we     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (trap)
                  state_next = ST_DONE;
               else if (req_we && req_size[1])
                  state_next = ST_WR;
               else
                  state_next = ST_RD;
            end
         end
         ST_RD:   state_next = we_reg ? ST_WR : ST_DONE;
         ST_WR: begin
            ram_we     = 1'b1;
            state_next = ST_DONE;
         end
         default: begin
            rsp_valid  = 1'b1;
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_reg        <= 1'b0;
         size_reg      <= SZ_BYTE;
         uns_reg       <= 1'b0;
         lane_reg      <= 2'b00;
         wdata_reg     <= '0;
         ram_addr_reg  <= '0;
         ram_din_reg   <= '0;
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= 1'b0;
      end else if (accept) begin
         we_reg        <= req_we;
         size_reg      <= req_size;
         uns_reg       <= req_unsigned;
         lane_reg      <= req_addr[1:0];
         wdata_reg     <= req_wdata;
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= trap;
         if (!trap)
            ram_addr_reg <= req_addr[ADDR_W-1:2];
         if (!trap && req_we && req_size[1])
            ram_din_reg <= req_wdata;
      end else if (state_reg == ST_RD) begin
         // RAM read completed at the preceding falling edge.
         if (we_reg)
            ram_din_reg <= store_word;
         else
            rsp_rdata_reg <= load_data;
      end
   end

   lsu_lane_align u_align (
      .size        (size_reg),
      .lane        (lane_reg),
      .is_unsigned (uns_reg),
      .rword       (ram_dout),
      .wdata       (wdata_reg),
      .load_data   (load_data),
      .store_word  (store_word)
   );

   assign ram_addr  = ram_addr_reg;
   assign ram_din   = ram_din_reg;
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural falling-edge RAM; expectations follow MISALIGN_TRAP_EN.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_err, ram_we;
   logic [31:0] rsp_rdata, ram_din;
   logic [31:0] ram_dout = 32'h0;
   logic [9:0]  ram_addr;

   logic [31:0] mem [1024];

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;   // load: rdata; store: RAM word afterwards
      int          lat;
      logic        err;
   } vec_t;

   vec_t vecs [17];

   lsu_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_din      (ram_din),
      .ram_dout     (ram_dout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ram_we)
         mem[ram_addr] <= ram_din;
      else
         ram_dout <= mem[ram_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [11:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp, input int lat, input logic err);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp = exp; v.lat = lat; v.err = err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic do_req(input vec_t v, input int idx);
      int          n;
      int          wecnt;
      logic [9:0]  waddr;
      logic        done;
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready", idx), {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 1; wecnt = 0; waddr = '0; done = 1'b0;
      while (!done) begin
         if (ram_we) begin
            wecnt++;
            waddr = ram_addr;
         end
         if (rsp_valid || n >= 10)
            done = 1'b1;
         else begin
            @(posedge clk); #1;
            n++;
         end
      end
      chk($sformatf("v%0d_rsp_valid", idx), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("v%0d_latency", idx), n, v.lat);
      chk($sformatf("v%0d_rdata", idx), rsp_rdata, v.we ? 32'h0 : v.exp);
      chk($sformatf("v%0d_err", idx), {31'b0, rsp_err}, {31'b0, v.err});
      chk($sformatf("v%0d_we_cycles", idx), wecnt, (v.we && !v.err) ? 1 : 0);
      if (v.we && !v.err)
         chk($sformatf("v%0d_waddr", idx), {22'b0, waddr}, {22'b0, v.addr[11:2]});
      if (v.we)
         chk($sformatf("v%0d_mem", idx), mem[v.addr[11:2]], v.exp);
      $display("txn %0d: we=%0b size=%0d addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
               idx, v.we, v.size, v.addr, v.wdata, rsp_rdata, rsp_err, n);
   endtask

   initial begin : main
      int cyc, n_acc, n_rsp, rsp_seen;
      int acc_cyc [3];
      logic acc_now;
      logic [11:0] seq_addr [3];
      logic [31:0] seq_exp [3];

      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

      vecs[0]  = mk(1, 2'b10, 0, 12'h010, 32'h12345678, 32'h12345678, 2, 0);
      vecs[1]  = mk(0, 2'b10, 0, 12'h010, 32'h0,        32'h12345678, 2, 0);
      vecs[2]  = mk(1, 2'b00, 0, 12'h012, 32'hFFFFFFAB, 32'h12AB5678, 3, 0);
      vecs[3]  = mk(0, 2'b00, 1, 12'h012, 32'h0,        32'h000000AB, 2, 0);
      vecs[4]  = mk(0, 2'b00, 0, 12'h012, 32'h0,        32'hFFFFFFAB, 2, 0);
      vecs[5]  = mk(1, 2'b01, 0, 12'h016, 32'h55558001, 32'h80010000, 3, 0);
      vecs[6]  = mk(0, 2'b01, 0, 12'h016, 32'h0,        32'hFFFF8001, 2, 0);
      vecs[7]  = mk(0, 2'b01, 1, 12'h016, 32'h0,        32'h00008001, 2, 0);
      vecs[8]  = mk(0, 2'b00, 0, 12'h010, 32'h0,        32'h00000078, 2, 0);
      vecs[9]  = mk(0, 2'b01, 0, 12'h010, 32'h0,        32'h00005678, 2, 0);
      vecs[10] = mk(1, 2'b00, 0, 12'h013, 32'h00000011, 32'h11AB5678, 3, 0);
`ifdef MISALIGN_TRAP_EN
      vecs[11] = mk(0, 2'b10, 0, 12'h013, 32'h0,        32'h00000000, 1, 1);
`else
      vecs[11] = mk(0, 2'b10, 0, 12'h013, 32'h0,        32'h11AB5678, 2, 0);
`endif
      vecs[12] = mk(0, 2'b11, 0, 12'h014, 32'h0,        32'h80010000, 2, 0);
      vecs[13] = mk(1, 2'b10, 0, 12'hFFC, 32'hDEADBEEF, 32'hDEADBEEF, 2, 0);
      vecs[14] = mk(0, 2'b10, 0, 12'hFFC, 32'h0,        32'hDEADBEEF, 2, 0);
`ifdef MISALIGN_TRAP_EN
      vecs[15] = mk(1, 2'b01, 0, 12'h011, 32'h0000BEEF, 32'h11AB5678, 1, 1);
      vecs[16] = mk(0, 2'b01, 1, 12'h011, 32'h0,        32'h00000000, 1, 1);
`else
      vecs[15] = mk(1, 2'b01, 0, 12'h011, 32'h0000BEEF, 32'h11ABBEEF, 3, 0);
      vecs[16] = mk(0, 2'b01, 1, 12'h011, 32'h0,        32'h0000BEEF, 2, 0);
`endif

      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      #2;
      chk("rst_ready",     {31'b0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rdata",     rsp_rdata, 32'h0);
      chk("rst_err",       {31'b0, rsp_err}, 32'd0);
      chk("rst_ram_we",    {31'b0, ram_we}, 32'd0);
      chk("rst_ram_addr",  {22'b0, ram_addr}, 32'h0);
      chk("rst_ram_din",   ram_din, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 17; i++)
         do_req(vecs[i], i);

      // Reset asserted while an SB is in its write cycle.
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 12'h018; req_wdata = 32'h00000077;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("abort_rd_we", {31'b0, ram_we}, 32'd0);
      @(posedge clk); #1;
      chk("abort_wr_we", {31'b0, ram_we}, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("abort_we_drop", {31'b0, ram_we}, 32'd0);
      chk("abort_rsp",     {31'b0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      rsp_seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid) rsp_seen++;
         @(posedge clk); #1;
      end
      chk("abort_no_rsp", rsp_seen, 0);
      chk("abort_ready",  {31'b0, req_ready}, 32'd1);
      $display("txn abort: SB @018 reset during WR -> ram_we=%0b rsp seen=%0d", ram_we, rsp_seen);

      // Three LWs with req_valid held continuously.
      seq_addr[0] = 12'h014; seq_exp[0] = 32'h80010000;
      seq_addr[1] = 12'hFFC; seq_exp[1] = 32'hDEADBEEF;
      seq_addr[2] = 12'h012; seq_exp[2] = vecs[15].we && !vecs[15].err ? 32'h11ABBEEF : 32'h11AB5678;
      cyc = 0; n_acc = 0; n_rsp = 0;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = seq_addr[0];
      while (n_rsp < 3 && cyc < 40) begin
         if (rsp_valid) begin
            chk($sformatf("seq_rdata%0d", n_rsp), rsp_rdata, seq_exp[n_rsp]);
            $display("txn seq%0d: LW -> rdata=%h at cycle %0d", n_rsp, rsp_rdata, cyc);
            n_rsp++;
         end
         acc_now = req_valid && req_ready;
         @(posedge clk); #1;
         cyc++;
         if (acc_now) begin
            chk($sformatf("seq_busy%0d", n_acc), {31'b0, req_ready}, 32'd0);
            acc_cyc[n_acc] = cyc;
            n_acc++;
            if (n_acc < 3)
               req_addr = seq_addr[n_acc];
            else
               req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      chk("seq_accepts",   n_acc, 3);
      chk("seq_responses", n_rsp, 3);
      if (n_acc == 3) begin
         chk("seq_gap01", acc_cyc[1] - acc_cyc[0], 3);
         chk("seq_gap12", acc_cyc[2] - acc_cyc[1], 3);
      end

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
